// File: rtl/ifetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package ifetch_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned PCW_W  = 30;

  // Word address PC[31:2]; byte address 0x3000.
  localparam logic [PCW_W-1:0] RESET_PC_DEFAULT = 30'h0000_0C00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifetch_queue_if.sv
// Instruction-memory request/acknowledge bus.
interface ifetch_queue_if;
  import ifetch_pkg::*;

  logic              im_req;
  logic [PCW_W-1:0]  im_addr;
  logic              im_ack;
  logic [INST_W-1:0] im_data;

  modport master (output im_req, output im_addr, input im_ack, input im_data);
  modport slave  (input im_req, input im_addr, output im_ack, output im_data);

endinterface

// File: rtl/ifetch_queue_fifo.sv
// Synchronous FIFO with flush; head read straight from registered storage.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Pointer/count next state; flush overrides push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: sequential PC generation, single-outstanding
// memory requests, prefetch queue and redirect handling.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int unsigned      DEPTH    = 4,
  parameter logic [PCW_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_i,
  input  logic [PCW_W-1:0]  redirect_pc_i,
  ifetch_queue_if.master    im,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [PCW_W-1:0]  inst_pc_o,
  input  logic              inst_ready_i
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [PCW_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PCW_W-1:0]  addr_q, addr_d;
  logic              req_q, req_d;

  logic [CW-1:0]     count;
  logic [CW-1:0]     next_count;
  logic              ack, push, pop, room;
  logic [PCW_W-1:0]  head_pc;
  logic [INST_W-1:0] head_inst;

  assign ack  = req_q & im.im_ack;
  assign push = ack & (state_q == FETCH) & ~redirect_i;
  assign pop  = inst_valid_o & inst_ready_i & ~redirect_i;
  // The outstanding request is counted once it is acked, so issuing only
  // while next_count < DEPTH leaves a slot for it.
  assign next_count = count + CW'(push) - CW'(pop);
  assign room       = next_count < CW'(DEPTH);

  sync_fifo #(
    .WIDTH (PCW_W + INST_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({addr_q, im.im_data}),
    .rdata_o ({head_pc, head_inst}),
    .count_o (count)
  );

  // Next-state for request FSM and fetch PC; redirect takes priority.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    req_d      = req_q;
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i;
      case (state_q)
        IDLE: begin
          state_d = FETCH;
          req_d   = 1'b1;
          addr_d  = redirect_pc_i;
        end
        FETCH, DRAIN: begin
          if (ack) begin
            state_d = FETCH;
            addr_d  = redirect_pc_i;
          end else begin
            state_d = DRAIN;
          end
        end
        default: begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          if (room) begin
            state_d = FETCH;
            req_d   = 1'b1;
            addr_d  = fetch_pc_q;
          end
        end
        FETCH: begin
          if (ack) begin
            fetch_pc_d = addr_q + PCW_W'(1);
            if (room) begin
              addr_d = addr_q + PCW_W'(1);
            end else begin
              state_d = IDLE;
              req_d   = 1'b0;
            end
          end
        end
        DRAIN: begin
          if (ack) begin
            state_d = FETCH;
            addr_d  = fetch_pc_q;
          end
        end
        default: begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      endcase
    end
  end

  // FSM, fetch PC and registered request outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= '0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
    end
  end

  assign im.im_req    = req_q;
  assign im.im_addr   = addr_q;
  assign inst_valid_o = (count != '0);
  assign inst_o       = inst_valid_o ? head_inst : '0;
  assign inst_pc_o    = inst_valid_o ? head_pc   : '0;

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios plus a randomized run against
// a transaction-level queue model.
module tb_ifetch_queue;
  import ifetch_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [29:0] RPC   = 30'h0000_0C00;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [29:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [29:0] inst_pc;
  logic        inst_ready;

  ifetch_queue_if bus();

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .im            (bus),
    .inst_valid_o  (inst_valid),
    .inst_o        (inst),
    .inst_pc_o     (inst_pc),
    .inst_ready_i  (inst_ready)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0, n_err = 0, n_acks = 0, n_pops = 0;

  // memory responder: 0 = fixed latency, 1 = random ack, 2 = manual ack
  int unsigned mem_mode, mem_lat, wcnt;
  logic        man_ack;

  typedef struct packed { logic [29:0] pc; logic [31:0] w; } ent_t;
  ent_t        mq[$];
  logic        m_stale;
  logic [29:0] m_fetch;
  logic        exp_valid, exp_req, exp_addr_chk;
  logic [29:0] exp_addr;
  ent_t        exp_head;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a[13:0], a[29:12]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic drive_mem();
    logic a;
    case (mem_mode)
      0:       a = bus.im_req && (wcnt >= mem_lat);
      1:       a = ($urandom_range(1, 0) != 0);
      default: a = man_ack;
    endcase
    bus.im_ack  = a;
    bus.im_data = (a && bus.im_req) ? mem_word(bus.im_addr) : $urandom;
    if (bus.im_req && !a) wcnt++;
    else wcnt = 0;
  endtask

  // Model: one request at a time; acked non-stale data joins a FIFO; a
  // request is issued whenever none is outstanding and the FIFO has room.
  task automatic model_edge();
    logic req, ack, pop;
    logic [29:0] a;
    ent_t e;
    req = bus.im_req; ack = bus.im_ack; a = bus.im_addr;
    if (rst) begin
      mq.delete();
      m_stale = 1'b0;
      m_fetch = RPC;
      exp_req = 1'b0;
      exp_addr = '0;
      exp_addr_chk = 1'b1;
    end else begin
      pop = (mq.size() != 0) && inst_ready && !redirect;
      if (pop) begin
        void'(mq.pop_front());
        n_pops++;
      end
      if (req && ack) begin
        n_acks++;
        if (!m_stale && !redirect) begin
          e.pc = a; e.w = bus.im_data;
          mq.push_back(e);
          m_fetch = a + 30'd1;
        end
        m_stale = 1'b0;
      end else if (req && redirect) begin
        m_stale = 1'b1;
      end
      if (redirect) begin
        mq.delete();
        m_fetch = redirect_pc;
      end
      if (req && !ack) begin
        exp_req = 1'b1;
        exp_addr = a;
      end else begin
        exp_req = (mq.size() < int'(DEPTH));
        exp_addr = m_fetch;
      end
      exp_addr_chk = exp_req;
    end
    exp_valid = (mq.size() != 0);
    exp_head  = exp_valid ? mq[0] : '0;
  endtask

  task automatic cycle();
    drive_mem();
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; inst_ready = 1'b0;
    mem_mode = 0; mem_lat = 0;
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    mem_mode = 2; man_ack = 1'b1;
    repeat (3) cycle();
    n_vec++;
    if ({bus.im_req, bus.im_addr, inst_valid, inst, inst_pc} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: req=%0b addr=%h valid=%0b inst=%h pc=%h, want all 0",
               bus.im_req, bus.im_addr, inst_valid, inst, inst_pc);
    end
    rst = 1'b0; man_ack = 1'b0;
    cycle();
    n_vec++;
    if (bus.im_req !== 1'b1 || bus.im_addr !== RPC) begin
      n_err++;
      $display("FAIL reset_first_req: req=%0b addr=%h want 1/%h", bus.im_req, bus.im_addr, RPC);
    end
    n_vec++;
    if (inst_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_first_valid: got %0b want 0", inst_valid);
    end
  endtask

  task automatic test_stream();
    logic [29:0] ea, ep;
    do_reset();
    inst_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      ea = 30'(RPC + 30'(k) - 30'd1);
      ep = 30'(RPC + 30'(k) - 30'd2);
      n_vec++;
      if (bus.im_req !== 1'b1 || bus.im_addr !== ea) begin
        n_err++;
        $display("FAIL stream_addr k=%0d: req=%0b addr=%h want 1/%h", k, bus.im_req, bus.im_addr, ea);
      end
      n_vec++;
      if (k == 1) begin
        if (inst_valid !== 1'b0) begin
          n_err++;
          $display("FAIL stream_first_valid: got %0b want 0", inst_valid);
        end
      end else if (inst_valid !== 1'b1 || inst_pc !== ep || inst !== mem_word(ep)) begin
        n_err++;
        $display("FAIL stream_head k=%0d: v=%0b pc=%h inst=%h want 1/%h/%h",
                 k, inst_valid, inst_pc, inst, ep, mem_word(ep));
      end
    end
  endtask

  task automatic test_full();
    int unsigned a0;
    logic [29:0] ep;
    do_reset();
    a0 = n_acks;
    repeat (10) cycle();
    n_vec++;
    if (n_acks - a0 != DEPTH) begin
      n_err++;
      $display("FAIL full_push_count: got %0d want %0d", n_acks - a0, DEPTH);
    end
    n_vec++;
    if (bus.im_req !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== RPC) begin
      n_err++;
      $display("FAIL full_idle: req=%0b v=%0b pc=%h want 0/1/%h", bus.im_req, inst_valid, inst_pc, RPC);
    end
    inst_ready = 1'b1;
    cycle();
    n_vec++;
    if (bus.im_req !== 1'b1 || bus.im_addr !== 30'(RPC + 30'd4)) begin
      n_err++;
      $display("FAIL full_resume: req=%0b addr=%h want 1/%h", bus.im_req, bus.im_addr, 30'(RPC + 30'd4));
    end
    for (int k = 1; k <= 8; k++) begin
      cycle();
      ep = 30'(RPC + 30'd1 + 30'(k));
      n_vec++;
      if (inst_valid !== 1'b1 || inst_pc !== ep || inst !== mem_word(ep)) begin
        n_err++;
        $display("FAIL full_order k=%0d: v=%0b pc=%h want 1/%h", k, inst_valid, inst_pc, ep);
      end
    end
  endtask

  task automatic test_latency();
    int unsigned a0, last_ack, n_ack, n_val;
    logic [29:0] pa;
    logic pr;
    do_reset();
    mem_lat = 3; inst_ready = 1'b1;
    last_ack = 0; n_ack = 0; n_val = 0;
    for (int unsigned k = 1; k <= 41; k++) begin
      a0 = n_acks; pa = bus.im_addr; pr = bus.im_req;
      cycle();
      if (n_acks != a0) begin
        if (n_ack > 0) begin
          n_vec++;
          if (k - last_ack != 4) begin
            n_err++;
            $display("FAIL lat_gap: got %0d want 4", k - last_ack);
          end
        end
        last_ack = k; n_ack++;
      end else if (pr) begin
        n_vec++;
        if (bus.im_addr !== pa) begin
          n_err++;
          $display("FAIL lat_hold: addr=%h want %h", bus.im_addr, pa);
        end
      end
      if (inst_valid) n_val++;
    end
    n_vec++;
    if (n_ack != 10 || n_val != 10) begin
      n_err++;
      $display("FAIL lat_rate: acks=%0d valid=%0d want 10/10", n_ack, n_val);
    end
  endtask

  task automatic test_redirect_drain();
    do_reset();
    repeat (3) cycle();
    mem_mode = 2; man_ack = 1'b0;
    n_vec++;
    if (bus.im_addr !== 30'(RPC + 30'd2) || inst_valid !== 1'b1) begin
      n_err++;
      $display("FAIL drain_setup: addr=%h v=%0b want %h/1", bus.im_addr, inst_valid, 30'(RPC + 30'd2));
    end
    redirect = 1'b1; redirect_pc = 30'h100;
    cycle();
    redirect = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (inst_valid !== 1'b0 || bus.im_req !== 1'b1 || bus.im_addr !== 30'(RPC + 30'd2)) begin
        n_err++;
        $display("FAIL drain_hold k=%0d: v=%0b req=%0b addr=%h want 0/1/%h",
                 k, inst_valid, bus.im_req, bus.im_addr, 30'(RPC + 30'd2));
      end
      if (k == 0) cycle();
    end
    man_ack = 1'b1;
    cycle();
    n_vec++;
    if (inst_valid !== 1'b0 || bus.im_req !== 1'b1 || bus.im_addr !== 30'h100) begin
      n_err++;
      $display("FAIL drain_discard: v=%0b req=%0b addr=%h want 0/1/100", inst_valid, bus.im_req, bus.im_addr);
    end
    mem_mode = 0; inst_ready = 1'b1;
    cycle();
    n_vec++;
    if (inst_valid !== 1'b1 || inst_pc !== 30'h100 || inst !== mem_word(30'h100)) begin
      n_err++;
      $display("FAIL drain_first: v=%0b pc=%h inst=%h want 1/100/%h", inst_valid, inst_pc, inst, mem_word(30'h100));
    end
  endtask

  task automatic test_redirect_ack();
    logic [29:0] rpc;
    do_reset();
    inst_ready = 1'b1;
    repeat (4) cycle();
    rpc = 30'($urandom);
    redirect = 1'b1; redirect_pc = rpc;
    cycle();
    redirect = 1'b0;
    n_vec++;
    if (inst_valid !== 1'b0 || bus.im_req !== 1'b1 || bus.im_addr !== rpc) begin
      n_err++;
      $display("FAIL rdack_flush: v=%0b req=%0b addr=%h want 0/1/%h", inst_valid, bus.im_req, bus.im_addr, rpc);
    end
    cycle();
    n_vec++;
    if (inst_valid !== 1'b1 || inst_pc !== rpc || inst !== mem_word(rpc)) begin
      n_err++;
      $display("FAIL rdack_nodrain: v=%0b pc=%h want 1/%h", inst_valid, inst_pc, rpc);
    end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    inst_ready = 1'b1;
    repeat (3) cycle();
    redirect = 1'b1; redirect_pc = 30'h3FFF_FFFF;
    cycle();
    redirect = 1'b0;
    n_vec++;
    if (bus.im_addr !== 30'h3FFF_FFFF) begin
      n_err++;
      $display("FAIL wrap_addr0: addr=%h want 3fffffff", bus.im_addr);
    end
    cycle();
    n_vec++;
    if (bus.im_addr !== 30'h0 || inst_pc !== 30'h3FFF_FFFF) begin
      n_err++;
      $display("FAIL wrap_addr1: addr=%h pc=%h want 0/3fffffff", bus.im_addr, inst_pc);
    end
    cycle();
    n_vec++;
    if (bus.im_addr !== 30'h1 || inst_pc !== 30'h0 || inst !== mem_word(30'h0)) begin
      n_err++;
      $display("FAIL wrap_pc: addr=%h pc=%h want 1/0", bus.im_addr, inst_pc);
    end
    rst = 1'b1;
    cycle();
    n_vec++;
    if ({bus.im_req, bus.im_addr, inst_valid, inst, inst_pc} !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs: req=%0b addr=%h v=%0b inst=%h pc=%h want all 0",
               bus.im_req, bus.im_addr, inst_valid, inst, inst_pc);
    end
    rst = 1'b0;
    cycle();
    n_vec++;
    if (bus.im_req !== 1'b1 || bus.im_addr !== RPC) begin
      n_err++;
      $display("FAIL midreset_restart: req=%0b addr=%h want 1/%h", bus.im_req, bus.im_addr, RPC);
    end
  endtask

  task automatic test_random();
    int unsigned p0;
    do_reset();
    mem_mode = 1;
    p0 = n_pops;
    for (int k = 0; k < 3000; k++) begin
      rst         = ($urandom_range(299, 0) == 0);
      inst_ready  = ($urandom_range(3, 0) != 0);
      redirect    = ($urandom_range(19, 0) == 0);
      redirect_pc = ($urandom_range(3, 0) == 0) ? 30'h3FFF_FFFE : 30'($urandom);
      cycle();
      n_vec++;
      if (inst_valid !== exp_valid) begin
        n_err++;
        $display("FAIL rnd_valid k=%0d: got %0b want %0b", k, inst_valid, exp_valid);
      end
      n_vec++;
      if (inst_pc !== exp_head.pc || inst !== exp_head.w) begin
        n_err++;
        $display("FAIL rnd_head k=%0d: pc=%h inst=%h want %h/%h", k, inst_pc, inst, exp_head.pc, exp_head.w);
      end
      n_vec++;
      if (bus.im_req !== exp_req) begin
        n_err++;
        $display("FAIL rnd_req k=%0d: got %0b want %0b", k, bus.im_req, exp_req);
      end
      if (exp_addr_chk) begin
        n_vec++;
        if (bus.im_addr !== exp_addr) begin
          n_err++;
          $display("FAIL rnd_addr k=%0d: got %h want %h", k, bus.im_addr, exp_addr);
        end
      end
    end
    rst = 1'b0; redirect = 1'b0;
    n_vec++;
    if (n_pops - p0 < 200) begin
      n_err++;
      $display("FAIL rnd_progress: %0d deliveries, want at least 200", n_pops - p0);
    end
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    bus.im_ack = 1'b0; bus.im_data = '0;
    mem_mode = 2; mem_lat = 0; wcnt = 0; man_ack = 1'b0;
    m_stale = 1'b0; m_fetch = RPC;
    exp_valid = 1'b0; exp_req = 1'b0; exp_addr = '0; exp_addr_chk = 1'b0; exp_head = '0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_full();
    test_latency();
    test_redirect_drain();
    test_redirect_ack();
    test_wrap_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register.
- Generates sequential word PCs and fetches from an instruction memory over a req/ack handshake that tolerates variable latency.
- Buffers fetched {pc, instruction} pairs in a small prefetch queue, so ID-stage stalls and memory latency are decoupled.
- Applies branch/jump redirects resolved in ID and discards any stale in-flight fetch.

Parameters:
- DEPTH, 4, prefetch queue entries; power of two, minimum 2.
- RESET_PC, 30'h0000_0C00, word address (PC[31:2]) fetched first after reset; byte address 0x3000.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- redirect  in  1  control transfer resolved in ID this cycle.
- redirect_pc  in  30  target word address, valid while redirect=1.
- im_req  out  1  fetch request to instruction memory.
- im_addr  out  30  word address of the request.
- im_ack  in  1  memory completes the request this cycle.
- im_data  in  32  instruction word, valid with im_ack.
- inst_valid  out  1  queue head holds a valid instruction.
- inst  out  32  head instruction; 0 when inst_valid=0.
- inst_pc  out  30  head word PC; 0 when inst_valid=0.
- inst_ready  in  1  IF/ID accepts the head (IFIDWrite).

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, fetch_pc=RESET_PC, count=0, queue pointers=0, storage cleared.
  - im_req=0, im_addr=0, inst_valid=0, inst=0, inst_pc=0.
  - Reset asserted mid-transaction drops the transaction; any im_ack arriving while rst=1 is ignored.
- Handshake:
  - im_req and im_addr are registered.
  - Once im_req=1, im_addr stays stable until an edge where im_ack=1; that edge completes the transaction.
  - At most one transaction outstanding. im_ack while im_req=0 is ignored.
- pop = inst_valid & inst_ready. next_count = count + push − pop.
- States:
  - IDLE, im_req=0: if next_count<DEPTH, go to FETCH with im_addr=fetch_pc.
  - FETCH, im_req=1, im_ack=1:
    - push {im_addr, im_data}; fetch_pc=im_addr+1.
    - If next_count<DEPTH, stay in FETCH with im_addr=im_addr+1; else go to IDLE.
  - FETCH, im_ack=0: hold.
  - DRAIN, im_req=1, address held: on im_ack, discard the data, set im_addr=fetch_pc (the redirect target), and go to FETCH.
- Redirect (highest priority):
  - Queue is emptied (count=0, pointers reset) and fetch_pc=redirect_pc.
  - An edge with both pop and redirect counts as a redirect only.
  - IDLE+redirect: FETCH next cycle with im_addr=redirect_pc.
  - FETCH+redirect+im_ack: data discarded, FETCH with im_addr=redirect_pc; no DRAIN.
  - FETCH+redirect, no im_ack: go to DRAIN.
  - DRAIN+redirect: stay in DRAIN (or FETCH if im_ack) and update fetch_pc to the newest target.
- Latency:
  - First im_req one cycle after rst deasserts, then two cycles from the rst-release edge.
  - With zero-wait memory, inst_valid is set on the edge after the acking cycle, and sustained throughput is 1 instr/cycle.
- Arithmetic: fetch_pc and im_addr increment modulo 2^30; 30'h3FFF_FFFF wraps to 0.
- Full queue: no request is issued once next_count would reach DEPTH. Push while full cannot occur, because the single outstanding request is reserved in the next_count check.
- Empty queue: inst_valid=0, and inst_ready is ignored.
- Queue order is strictly FIFO; the head is a registered storage read with no bypass from im_data.

Decomposition:
- Package ifetch_pkg:
  - state enum {IDLE, FETCH, DRAIN};
  - RESET_PC_DEFAULT;
  - INST_W=32, PCW_W=30.
- One sub-module, sync_fifo, parameterised by width and depth:
  - push/pop/flush with flush priority;
  - count output;
  - wrap-around pointers.
- ifetch_queue holds the FSM and the fetch_pc counter.

Test Plan:
- Reset release, im_ack tied 1, inst_ready=1 → im_addr sequence 0xC00, 0xC01, …; inst_pc sequence 0xC00, 0xC01, … at 1/cycle; inst equals the memory word at each address.
- inst_ready=0, zero-wait memory → exactly DEPTH(4) pushes (0xC00–0xC03), then im_req=0; raise inst_ready → fetch resumes at 0xC04 with no lost or duplicated entry.
- Memory with 3-cycle ack latency → im_addr held constant across the 3 wait cycles; one instruction delivered per 4 cycles.
- redirect=1, redirect_pc=0x100 while a request to 0xC02 is pending with no ack → DRAIN; on the ack the 0xC02 data is discarded; next im_addr=0x100; first inst_pc out is 0x100; the queue was empty from the redirect edge.
- redirect and im_ack in the same cycle with queue non-empty and pop=1 → queue empty next cycle, acked data dropped, im_addr=redirect_pc, no DRAIN entered.
- redirect_pc=30'h3FFF_FFFF → fetches 0x3FFFFFFF then 0x00000000; rst pulsed mid-FETCH → all outputs 0 and im_req re-asserts at 0xC00.
